// File: rtl/udp_field_extract.sv
// ============================================================================
// udp_field_extract: pulls a fixed-offset multi-byte field out of a UDP payload
// byte stream and reports completed and short packets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_field_extract #(
    parameter int FIELD_OFFSET = 2,
    parameter int FIELD_BYTES  = 4,
    parameter bit BIG_ENDIAN   = 1
) (
    input  logic                     udp_rx_clk,
    input  logic                     reset,
    input  logic                     app_rx_data_valid,
    input  logic [7:0]               app_rx_data,
    input  logic [15:0]              app_rx_data_length,
    output logic [8*FIELD_BYTES-1:0] data_out,
    output logic                     data_out_valid,
    output logic                     short_pkt_err,
    output logic [15:0]              pkt_cnt
);

    localparam logic [31:0] FIELD_START = 32'(FIELD_OFFSET);
    localparam logic [31:0] FIELD_END   = 32'(FIELD_OFFSET + FIELD_BYTES);
    localparam logic [31:0] FIELD_LAST  = 32'(FIELD_OFFSET + FIELD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        FIELD = 2'd2,
        POST  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [15:0]              cnt;
    logic [15:0]              cnt_next;
    logic [15:0]              len;
    logic [15:0]              eff_len;
    logic [31:0]              cnt32;
    logic [31:0]              cnt_next32;
    logic [8*FIELD_BYTES-1:0] shadow;
    logic [8*FIELD_BYTES-1:0] shadow_next;
    logic                     pkt_end;
    logic                     field_last;
    logic                     field_en;

    always_comb begin
        eff_len = len;
        if (cnt == 16'd0) begin
            eff_len = (app_rx_data_length == 16'd0) ? 16'd1 : app_rx_data_length;
        end
        cnt32      = {16'd0, cnt};
        pkt_end    = app_rx_data_valid && (cnt == eff_len - 16'd1);
        field_last = app_rx_data_valid && (cnt32 == FIELD_LAST);
        cnt_next   = pkt_end ? 16'd0 : cnt + 16'd1;
        cnt_next32 = {16'd0, cnt_next};
        // IDLE sits on byte 0, which is already a field byte when the offset is zero
        field_en   = (state == FIELD) || ((state == IDLE) && (FIELD_OFFSET == 0));
    end

    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < FIELD_BYTES; k++) begin
            if (app_rx_data_valid && field_en && (cnt32 == FIELD_START + 32'(k))) begin
                if (BIG_ENDIAN) begin
                    shadow_next[8*(FIELD_BYTES-k)-1 -: 8] = app_rx_data;
                end else begin
                    shadow_next[8*k+7 -: 8] = app_rx_data;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        if (app_rx_data_valid) begin
            if (pkt_end) begin
                state_next = IDLE;
            end else if (cnt_next32 < FIELD_START) begin
                state_next = PRE;
            end else if (cnt_next32 < FIELD_END) begin
                state_next = FIELD;
            end else begin
                state_next = POST;
            end
        end
    end

    always_ff @(posedge udp_rx_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge udp_rx_clk) begin
        if (reset) begin
            cnt            <= 16'd0;
            len            <= 16'd0;
            shadow         <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            short_pkt_err  <= 1'b0;
            pkt_cnt        <= 16'd0;
        end else begin
            data_out_valid <= 1'b0;
            short_pkt_err  <= 1'b0;
            if (app_rx_data_valid) begin
                cnt <= cnt_next;
                if (cnt == 16'd0) begin
                    len <= eff_len;
                end
                // a packet end always drops the shadow; a complete field was copied out already
                shadow <= pkt_end ? '0 : shadow_next;
                if (field_last) begin
                    data_out       <= shadow_next;
                    data_out_valid <= 1'b1;
                end
                if (pkt_end) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                    if (cnt32 < FIELD_LAST) begin
                        short_pkt_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_udp_field_extract.sv
// ============================================================================
// tb_udp_field_extract: bench for udp_field_extract, both byte orders in parallel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_field_extract;

    localparam int OFF = 2;
    localparam int FB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        v;
    logic [7:0]  d;
    logic [15:0] l;
    logic [31:0] do_be, do_le;
    logic        dv_be, dv_le, err_be, err_le;
    logic [15:0] pc_be, pc_le;

    always #5 clk = ~clk;

    udp_field_extract #(.FIELD_OFFSET(OFF), .FIELD_BYTES(FB), .BIG_ENDIAN(1)) dut (
        .udp_rx_clk(clk), .reset(reset), .app_rx_data_valid(v), .app_rx_data(d),
        .app_rx_data_length(l), .data_out(do_be), .data_out_valid(dv_be),
        .short_pkt_err(err_be), .pkt_cnt(pc_be));

    udp_field_extract #(.FIELD_OFFSET(OFF), .FIELD_BYTES(FB), .BIG_ENDIAN(0)) dut_le (
        .udp_rx_clk(clk), .reset(reset), .app_rx_data_valid(v), .app_rx_data(d),
        .app_rx_data_length(l), .data_out(do_le), .data_out_valid(dv_le),
        .short_pkt_err(err_le), .pkt_cnt(pc_le));

    int checks = 0;
    int fails  = 0;
    bit quiet  = 1'b0;
    int dv_seen, err_seen;

    // reference model state: position in packet, length, collected field bytes
    int          m_pos = 0;
    int          m_len = 0;
    logic [7:0]  m_field [FB];
    logic [31:0] m_be = 0, m_le = 0;
    bit          m_dv = 0, m_err = 0;
    int          m_cnt = 0;

    typedef struct {
        logic [15:0] len;
        int          n;
        logic [7:0]  base;
        logic [7:0]  step;
        int          gap;
        logic [31:0] e_be;
        logic [31:0] e_le;
        int          e_dv;
        int          e_err;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input bit rst, input bit vv, input logic [7:0] dd, input logic [15:0] ll);
        logic [31:0] be, le;
        if (rst) begin
            m_pos = 0; m_len = 0; m_be = 0; m_le = 0;
            m_dv = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_dv = 0; m_err = 0;
            if (vv) begin
                if (m_pos == 0) m_len = (ll == 0) ? 1 : int'(ll);
                if (m_pos >= OFF && m_pos < OFF + FB) m_field[m_pos-OFF] = dd;
                if (m_pos == OFF + FB - 1) begin
                    be = 0; le = 0;
                    for (int k = 0; k < FB; k++) begin
                        be = be | (32'(m_field[k]) << (8 * (FB - 1 - k)));
                        le = le | (32'(m_field[k]) << (8 * k));
                    end
                    m_be = be; m_le = le; m_dv = 1;
                end
                if (m_pos == m_len - 1) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (m_pos < OFF + FB - 1) m_err = 1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit vv, input logic [7:0] dd, input logic [15:0] ll);
        reset = rst; v = vv; d = dd; l = ll;
        @(posedge clk);
        model(rst, vv, dd, ll);
        #1;
        if (!quiet) begin
            chk("data_out_be", {32'd0, do_be}, {32'd0, m_be});
            chk("data_out_le", {32'd0, do_le}, {32'd0, m_le});
            chk("data_out_valid", {63'd0, dv_be}, {63'd0, m_dv});
            chk("data_out_valid_le", {63'd0, dv_le}, {63'd0, m_dv});
            chk("short_pkt_err", {63'd0, err_be}, {63'd0, m_err});
            chk("short_pkt_err_le", {63'd0, err_le}, {63'd0, m_err});
            chk("pkt_cnt", {48'd0, pc_be}, 64'(m_cnt));
            chk("valid_err_exclusive", {63'd0, dv_be & err_be}, 64'd0);
        end
        if (dv_be) dv_seen++;
        if (err_be) err_seen++;
    endtask

    // length is only meaningful on byte 0; later bytes carry junk lengths
    task automatic send_pkt(input logic [15:0] len, input int n, input logic [7:0] base,
                            input logic [7:0] step, input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, base + 8'(i) * step, (i == 0) ? len : 16'($urandom));
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 8'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        tbl[0] = '{16'd8, 8, 8'h00, 8'h01, 0, 32'h02030405, 32'h05040302, 1, 0, 16'd1};
        tbl[1] = '{16'd8, 8, 8'h00, 8'h01, 1, 32'h02030405, 32'h05040302, 1, 0, 16'd2};
        tbl[2] = '{16'd4, 4, 8'hAA, 8'h11, 0, 32'h02030405, 32'h05040302, 0, 1, 16'd3};
        tbl[3] = '{16'd6, 6, 8'h10, 8'h01, 0, 32'h12131415, 32'h15141312, 1, 0, 16'd4};
        tbl[4] = '{16'd0, 1, 8'h99, 8'h01, 0, 32'h12131415, 32'h15141312, 0, 1, 16'd5};
        tbl[5] = '{16'd5, 5, 8'h40, 8'h01, 0, 32'h12131415, 32'h15141312, 0, 1, 16'd6};

        cycle(1'b1, 1'b0, 8'h00, 16'd0);
        cycle(1'b1, 1'b1, 8'h55, 16'd3);
        chk("reset data_out", {32'd0, do_be}, 64'd0);
        chk("reset valid", {63'd0, dv_be | err_be}, 64'd0);
        chk("reset pkt_cnt", {48'd0, pc_be}, 64'd0);

        for (int r = 0; r < 6; r++) begin
            dv_seen = 0; err_seen = 0;
            send_pkt(tbl[r].len, tbl[r].n, tbl[r].base, tbl[r].step, tbl[r].gap);
            cycle(1'b0, 1'b0, 8'h00, 16'd0);
            chk($sformatf("row%0d data_out_be", r), {32'd0, do_be}, {32'd0, tbl[r].e_be});
            chk($sformatf("row%0d data_out_le", r), {32'd0, do_le}, {32'd0, tbl[r].e_le});
            chk($sformatf("row%0d valid_pulses", r), 64'(dv_seen), 64'(tbl[r].e_dv));
            chk($sformatf("row%0d err_pulses", r), 64'(err_seen), 64'(tbl[r].e_err));
            chk($sformatf("row%0d pkt_cnt", r), {48'd0, pc_be}, {48'd0, tbl[r].e_pc});
        end

        // reset in the middle of a packet, with valid high on the reset cycle
        cycle(1'b1, 1'b0, 8'h00, 16'd0);
        send_pkt(16'd8, 4, 8'h00, 8'h01, 0);
        cycle(1'b1, 1'b1, 8'h04, 16'd8);
        dv_seen = 0; err_seen = 0;
        send_pkt(16'd8, 8, 8'h20, 8'h01, 0);
        cycle(1'b0, 1'b0, 8'h00, 16'd0);
        chk("midreset data_out_be", {32'd0, do_be}, 64'h22232425);
        chk("midreset data_out_le", {32'd0, do_le}, 64'h25242322);
        chk("midreset err_pulses", 64'(err_seen), 64'd0);
        chk("midreset valid_pulses", 64'(dv_seen), 64'd1);
        chk("midreset pkt_cnt", {48'd0, pc_be}, 64'd1);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom), 16'($urandom_range(0, 12)));
        end

        // pkt_cnt wrap using one-byte packets
        cycle(1'b1, 1'b0, 8'h00, 16'd0);
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) cycle(1'b0, 1'b1, 8'h77, 16'd0);
        quiet = 1'b0;
        chk("pkt_cnt max", {48'd0, pc_be}, 64'hFFFF);
        cycle(1'b0, 1'b1, 8'h77, 16'd1);
        chk("pkt_cnt wrap", {48'd0, pc_be}, 64'd0);
        chk("pkt_cnt wrap le", {48'd0, pc_le}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
